// File: rtl/encrypt_function_1.sv
// encrypt_function_1: two-stage encryption pipeline.
// Each 60-bit plaintext word is added to a 60-bit key derived from an 11-bit
// Fibonacci LFSR. The result is packed into a 78-bit frame
// {y[60:0], rand[10:0], FUNC_ID[5:0]}.
// Optional feature macro: ENC_SEED_LOAD_EN adds the seed_load/seed_in ports,
// which reload the LFSR at run time.
module encrypt_function_1 #(
  parameter logic [10:0] SEED    = 11'h001,
  parameter logic [5:0]  FUNC_ID = 6'd1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        in_valid,
  input  logic [59:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [77:0] out_data,
  input  logic        out_ready,
  output logic [15:0] frame_cnt
`ifdef ENC_SEED_LOAD_EN
  ,
  input  logic        seed_load,
  input  logic [10:0] seed_in
`endif
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [10:0] SeedEff = (SEED == 11'd0) ? 11'h001 : SEED;

  // Key pattern: the random value and its complement tiled across 60 bits.
  function automatic logic [59:0] keyFromRand(input logic [10:0] r);
    return {r[4:0], ~r, r, ~r, ~r, r};
  endfunction

  logic [10:0] lfsr_q, lfsr_d;
  logic        s1Valid_q, s1Valid_d;
  logic [59:0] s1X_q, s1X_d;
  logic [10:0] s1Rand_q, s1Rand_d;
  logic        outValid_q, outValid_d;
  logic [77:0] outData_q, outData_d;
  logic [15:0] frameCnt_q, frameCnt_d;

  logic        s2En;
  logic        s1En;
  logic        accept;
  logic [60:0] sum;

  assign s2En      = ~outValid_q | out_ready;
  assign s1En      = ~s1Valid_q | s2En;
  assign accept    = in_valid & s1En;
  assign sum       = {1'b0, s1X_q} + {1'b0, keyFromRand(s1Rand_q)};

  assign in_ready  = s1En;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign frame_cnt = frameCnt_q;

  // Next-state logic for the LFSR, both pipeline stages and the frame counter.
  always_comb begin
    lfsr_d     = lfsr_q;
    s1Valid_d  = s1Valid_q;
    s1X_d      = s1X_q;
    s1Rand_d   = s1Rand_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    frameCnt_d = frameCnt_q;

    if (accept) begin
      lfsr_d = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    end
`ifdef ENC_SEED_LOAD_EN
    if (seed_load) begin
      lfsr_d = (seed_in == 11'd0) ? 11'h001 : seed_in;
    end
`endif

    if (s1En) begin
      s1Valid_d = in_valid;
      if (accept) begin
        s1X_d    = in_data;
        s1Rand_d = lfsr_q;
      end
    end

    if (s2En) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        outData_d = {sum, s1Rand_q, FUNC_ID};
      end
    end

    if (outValid_q && out_ready) begin
      frameCnt_d = frameCnt_q + 16'd1;
    end
  end

  // State registers; reset discards every in-flight word and restarts the key.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lfsr_q     <= SeedEff;
      s1Valid_q  <= 1'b0;
      s1X_q      <= '0;
      s1Rand_q   <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      frameCnt_q <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      s1Valid_q  <= s1Valid_d;
      s1X_q      <= s1X_d;
      s1Rand_q   <= s1Rand_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      frameCnt_q <= frameCnt_d;
    end
  end

endmodule

// File: tb/tb_encrypt_function_1.sv
// Testbench for encrypt_function_1: directed vectors plus a scoreboard.
// Expected frames are queued at input-accept time. A monitor pops and compares
// them whenever a frame is handed downstream.
module tb_encrypt_function_1;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [59:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [77:0] out_data;
  logic        out_ready = 1'b1;
  logic [15:0] frame_cnt;
`ifdef ENC_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [10:0] seed_in = '0;
`endif

  encrypt_function_1 #(.SEED(11'h001), .FUNC_ID(6'd1)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
`ifdef ENC_SEED_LOAD_EN
    ,
    .seed_load (seed_load),
    .seed_in   (seed_in)
`endif
  );

  typedef struct {
    logic [59:0] x;
    logic [77:0] frame;
  } expEntry_t;

  expEntry_t   expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [10:0] modelLfsr = 11'h001;
  int          sentCount = 0;
  int          cycleCount = 0;
  int          frameCycles[$];
  bit          trackRand = 1'b0;
  bit          seen[2048];
  int          distinct = 0;
  bit          randReady = 1'b0;

  // Free-running clock, 10 time units per cycle.
  always #5 Clk = ~Clk;

  // Cycle counter used to timestamp frames.
  always @(posedge Clk) cycleCount <= cycleCount + 1;

  function automatic logic [59:0] keyB(input logic [10:0] r);
    return {r[4:0], ~r, r, ~r, ~r, r};
  endfunction

  function automatic logic [77:0] modelFrame(input logic [59:0] x, input logic [10:0] r);
    logic [60:0] y;
    y = {1'b0, x} + {1'b0, keyB(r)};
    return {y, r, 6'd1};
  endfunction

  task automatic checkOutput(input string name, input logic [77:0] act, input logic [77:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every downstream transfer is checked against the scoreboard head.
  always @(negedge Clk) begin
    if (Rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_frame: got %h expected none", out_data);
      end else begin
        expEntry_t   e;
        logic [60:0] decX;
        logic [10:0] r;
        e = expQ.pop_front();
        r = out_data[16:6];
        decX = out_data[77:17] - {1'b0, keyB(r)};
        checkOutput("frame", out_data, e.frame);
        checkOutput("decrypt", {17'b0, decX}, {18'b0, e.x});
        frameCycles.push_back(cycleCount);
        if (trackRand) begin
          compared++;
          if (r == 11'd0 || seen[r]) begin
            mismatched++;
            $display("[TB] FAIL rand_unique: got %h expected fresh nonzero value", r);
          end else begin
            seen[r] = 1'b1;
            distinct++;
          end
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge Clk);
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one word for up to maxCycles; on accept push the expected frame.
  task automatic applyStimulus(input logic [59:0] x, input bit useHand, input logic [77:0] hand,
                               input int maxCycles, output bit accepted);
    expEntry_t e;
    in_valid = 1'b1;
    in_data  = x;
    accepted = 1'b0;
    for (int c = 0; c < maxCycles && !accepted; c++) begin
      @(negedge Clk);
      if (in_ready) begin
        e.x     = x;
        e.frame = useHand ? hand : modelFrame(x, modelLfsr);
        expQ.push_back(e);
        modelLfsr = {modelLfsr[9:0], modelLfsr[10] ^ modelLfsr[8]};
        sentCount++;
        accepted = 1'b1;
      end
      nextCycle();
    end
  endtask

  task automatic sendWord(input logic [59:0] x);
    bit acc;
    applyStimulus(x, 1'b0, '0, 200, acc);
    if (!acc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (expQ.size() != 0 && c < 500) begin
      nextCycle();
      c++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_drain: got %0d frames pending expected 0", name, expQ.size());
    end
    nextCycle();
  endtask

  task automatic applyReset(input string name);
    Rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput({name, "_out_valid"}, {77'b0, out_valid}, 78'd0);
    checkOutput({name, "_frame_cnt"}, {62'b0, frame_cnt}, 78'd0);
    checkOutput({name, "_out_data"}, out_data, 78'd0);
    expQ.delete();
    frameCycles.delete();
    modelLfsr = 11'h001;
    sentCount = 0;
    @(posedge Clk);
    #3;
    Rst_n = 1'b1;
    @(negedge Clk);
    checkOutput({name, "_in_ready"}, {77'b0, in_ready}, 78'd1);
    nextCycle();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          acc;
    logic [77:0] held;
    int          lat;

    // Test 1: single word, hand-computed frame and 2-cycle latency.
    applyReset("reset");
    out_ready = 1'b1;
    applyStimulus(60'h0123456789ABCDE, 1'b1, {61'h0112145A785AACDF, 11'h001, 6'd1}, 20, acc);
    idle();
    lat = 1;
    @(negedge Clk);
    while (!out_valid && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
    checkOutput("latency", 78'(lat), 78'd2);
    drain("t1");

    // Test 2: back-to-back words, consecutive frames, counter value.
    applyReset("reset2");
    for (int i = 0; i < 4; i++) sendWord(60'(i));
    idle();
    drain("t2");
    for (int i = 1; i < 4 && i < frameCycles.size(); i++)
      checkOutput("consecutive", 78'(frameCycles[i] - frameCycles[i-1]), 78'd1);
    checkOutput("frame_cnt_4", {62'b0, frame_cnt}, 78'd4);

    // Test 3: all-ones word produces a carry into y[60].
    applyReset("reset3");
    applyStimulus(60'hFFFFFFFFFFFFFFF, 1'b1, {61'h10FFE003FFBFF000, 11'h001, 6'd1}, 20, acc);
    idle();
    drain("t3");

    // Test 4: downstream stall admits two words and holds the output frame.
    applyReset("reset4");
    out_ready = 1'b0;
    sendWord(60'h0000000000000AA);
    sendWord(60'h0000000000000BB);
    held = out_data;
    applyStimulus(60'h0000000000000CC, 1'b0, '0, 5, acc);
    checkOutput("stall_accept", {77'b0, acc}, 78'd0);
    checkOutput("stall_in_ready", {77'b0, in_ready}, 78'd0);
    checkOutput("stall_out_valid", {77'b0, out_valid}, 78'd1);
    checkOutput("stall_hold", out_data, held);
    out_ready = 1'b1;
    sendWord(60'h0000000000000CC);
    idle();
    drain("t4");
    checkOutput("frame_cnt_3", {62'b0, frame_cnt}, 78'd3);

    // Test 5: reset in mid-stream clears everything; key restarts at seed.
    for (int i = 0; i < 5; i++) sendWord(60'h123 + 60'(i));
    #2;
    applyReset("midreset");
    sendWord(60'h0FEDCBA98765432);
    idle();
    drain("t5");
    checkOutput("frame_cnt_1", {62'b0, frame_cnt}, 78'd1);

`ifdef ENC_SEED_LOAD_EN
    // Test 6: run-time seed reload, zero replaced by 1.
    applyReset("reset6");
    sendWord(60'h111);
    idle();
    seed_in = 11'd0;
    seed_load = 1'b1;
    nextCycle();
    seed_load = 1'b0;
    modelLfsr = 11'h001;
    sendWord(60'h222);
    idle();
    seed_in = 11'h5A5;
    seed_load = 1'b1;
    nextCycle();
    seed_load = 1'b0;
    modelLfsr = 11'h5A5;
    sendWord(60'h333);
    idle();
    drain("t6");
`endif

    // Full-period run with random backpressure: every rand value appears once.
    applyReset("reset7");
    for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
    distinct = 0;
    trackRand = 1'b1;
    randReady = 1'b1;
    for (int i = 0; i < 2047; i++) sendWord({$urandom, $urandom} & 60'hFFFFFFFFFFFFFFF);
    idle();
    randReady = 1'b0;
    out_ready = 1'b1;
    drain("t7");
    trackRand = 1'b0;
    checkOutput("distinct_rand", 78'(distinct), 78'd2047);
    checkOutput("frame_cnt_2047", {62'b0, frame_cnt}, 78'd2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
